dmx_tx_core: RTL and testbench

//   Single-clock DMX512 slot transmitter. Sits downstream of the GPMC register decode and

---
 rtl/dmx_tx_pkg.sv | 25 ++
 rtl/dmx_tx_core_sync_fifo.sv | 94 +++++++++
 rtl/dmx_tx_core.sv | 197 +++++++++++++++++++
 tb/tb_dmx_tx_core.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmx_tx_pkg.sv
// Shared constants and state encoding for the DMX512 slot transmitter.
// Timing defaults assume a 20 MHz clock and a 250 kbaud line.
package dmx_tx_pkg;

   localparam int DMX_BAUD_CLKS  = 80;
   localparam int DMX_BREAK_BITS = 25;
   localparam int DMX_MAB_BITS   = 3;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_BREAK = 3'd1;
   localparam logic [2:0] ST_MAB   = 3'd2;
   localparam logic [2:0] ST_START = 3'd3;
   localparam logic [2:0] ST_DATA  = 3'd4;
   localparam logic [2:0] ST_STOP  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_BREAK = ST_BREAK,
      S_MAB   = ST_MAB,
      S_START = ST_START,
      S_DATA  = ST_DATA,
      S_STOP  = ST_STOP
   } dmx_state_e;

endpackage

// File: rtl/dmx_tx_core_sync_fifo.sv
// Single-clock FIFO with registered read port so the storage maps onto block RAM.
// full/empty/level are registered; a push at full is ignored even if a pop happens.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int AW    = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   input  logic             rd,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   localparam logic [AW:0]   DEPTH    = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

   logic [WIDTH-1:0] mem [0:(2**AW)-1];
   logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic [WIDTH-1:0] dout_q;
   logic             push_s, pop_s;

   // pointer and occupancy next-state
   always_comb begin
      push_s = wr && !full_q;
      pop_s  = rd && !empty_q;
      if (push_s) begin
         wp_d = wp_q + PTR_ONE;
      end else begin
         wp_d = wp_q;
      end
      if (pop_s) begin
         rp_d = rp_q + PTR_ONE;
      end else begin
         rp_d = rp_q;
      end
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      full_d  = (cnt_d == DEPTH);
      empty_d = (cnt_d == CNT_ZERO);
   end

   // pointer and flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q    <= PTR_ZERO;
         rp_q    <= PTR_ZERO;
         cnt_q   <= CNT_ZERO;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   // storage write port (no reset so it stays RAM-inferable)
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem[wp_q] <= din;
      end
   end

   // registered read port
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q <= {WIDTH{1'b0}};
      end else if (pop_s) begin
         dout_q <= mem[rp_q];
      end else begin
         dout_q <= dout_q;
      end
   end

   assign dout  = dout_q;
   assign full  = full_q;
   assign empty = empty_q;
   assign level = cnt_q;

endmodule

// File: rtl/dmx_tx_core.sv
// DMX512 slot transmitter: FIFO-fed, emits BREAK+MAB before start-code entries,
// then serialises each entry as 8N2. dmx_txd is registered and idles at mark.
module dmx_tx_core
   import dmx_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DMX_BAUD_CLKS,
   parameter int BREAK_BITS   = DMX_BREAK_BITS,
   parameter int MAB_BITS     = DMX_MAB_BITS,
   parameter int FIFO_AW      = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr,
   input  logic [8:0]         wr_data,
   output logic               full,
   output logic [FIFO_AW:0]   level,
   output logic               overflow,
   output logic               busy,
   output logic               dmx_txd
);

   localparam int CW = $clog2(BREAK_BITS * CLKS_PER_BIT);
   localparam logic [CW-1:0] CC_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CC_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BRK_LAST = CW'(BREAK_BITS * CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MAB_LAST = CW'(MAB_BITS * CLKS_PER_BIT - 1);

   dmx_state_e      state_q, state_d;
   logic [CW-1:0]   cc_q, cc_d;
   logic [2:0]      bc_q, bc_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            sop_q, sop_d;
   logic            ld_q, ld_d;
   logic            txd_q, txd_d;
   logic            busy_q, busy_d;
   logic            ovf_q, ovf_d;
   logic            rd_s, bit_end_s;
   logic [8:0]      fifo_dout_s;
   logic            fifo_full_s, fifo_empty_s;
   logic [FIFO_AW:0] fifo_level_s;

   sync_fifo #(
      .WIDTH (9),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr),
      .din   (wr_data),
      .rd    (rd_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (fifo_level_s)
   );

   // transmitter next-state, counters and shift register
   always_comb begin
      rd_s      = (state_q == S_IDLE) && !fifo_empty_s;
      bit_end_s = (cc_q == BIT_LAST);
      state_d   = state_q;
      cc_d      = cc_q;
      bc_d      = bc_q;
      shreg_d   = shreg_q;
      sop_d     = sop_q;
      ld_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            cc_d = CC_ZERO;
            bc_d = 3'd0;
            if (rd_s) begin
               state_d = S_START;
               ld_d    = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            // Registered FIFO read: the entry arrives one cycle after the pop, while
            // the line is already low; a start code turns this cycle into break cycle 0.
            if (ld_q) begin
               shreg_d = fifo_dout_s[7:0];
               sop_d   = fifo_dout_s[8];
            end else begin
               shreg_d = shreg_q;
               sop_d   = sop_q;
            end
            if (ld_q && fifo_dout_s[8]) begin
               state_d = S_BREAK;
               cc_d    = cc_q + CC_ONE;
            end else if (bit_end_s) begin
               state_d = S_DATA;
               cc_d    = CC_ZERO;
               bc_d    = 3'd0;
            end else begin
               cc_d    = cc_q + CC_ONE;
            end
         end
         S_BREAK: begin
            if (cc_q == BRK_LAST) begin
               state_d = S_MAB;
               cc_d    = CC_ZERO;
            end else begin
               cc_d    = cc_q + CC_ONE;
            end
         end
         S_MAB: begin
            if (cc_q == MAB_LAST) begin
               state_d = S_START;
               cc_d    = CC_ZERO;
            end else begin
               cc_d    = cc_q + CC_ONE;
            end
         end
         S_DATA: begin
            if (bit_end_s) begin
               cc_d    = CC_ZERO;
               shreg_d = {1'b0, shreg_q[7:1]};
               if (bc_q == 3'd7) begin
                  state_d = S_STOP;
                  bc_d    = 3'd0;
               end else begin
                  bc_d    = bc_q + 3'd1;
               end
            end else begin
               cc_d = cc_q + CC_ONE;
            end
         end
         S_STOP: begin
            if (bit_end_s) begin
               cc_d = CC_ZERO;
               if (bc_q == 3'd1) begin
                  state_d = S_IDLE;
                  bc_d    = 3'd0;
               end else begin
                  bc_d    = bc_q + 3'd1;
               end
            end else begin
               cc_d = cc_q + CC_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cc_d    = CC_ZERO;
            bc_d    = 3'd0;
         end
      endcase
   end

   // line level, busy and sticky overflow derived from the next state
   always_comb begin
      case (state_d)
         S_IDLE:  txd_d = 1'b1;
         S_BREAK: txd_d = 1'b0;
         S_MAB:   txd_d = 1'b1;
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shreg_d[0];
         S_STOP:  txd_d = 1'b1;
         default: txd_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
      ovf_d  = ovf_q | (wr & fifo_full_s);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cc_q    <= CC_ZERO;
         bc_q    <= 3'd0;
         shreg_q <= 8'h00;
         sop_q   <= 1'b0;
         ld_q    <= 1'b0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cc_q    <= cc_d;
         bc_q    <= bc_d;
         shreg_q <= shreg_d;
         sop_q   <= sop_d;
         ld_q    <= ld_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign full     = fifo_full_s;
   assign level    = fifo_level_s;
   assign overflow = ovf_q;
   assign busy     = busy_q;
   assign dmx_txd  = txd_q;

endmodule

// File: tb/tb_dmx_tx_core.sv
// Self-checking bench for dmx_tx_core: a queue-based reference model predicts
// FIFO status and frame start cycles; a negedge monitor decodes the line.
`timescale 1ns/1ps
module tb_dmx_tx_core;

   localparam int CPB    = 80;
   localparam int FRAME  = 11 * CPB;
   localparam int BRKMAB = (25 + 3) * CPB;
   localparam int DEPTH  = 512;

   typedef struct {
      bit         sop;
      bit [7:0]   data;
      longint     start;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr = 1'b0;
   logic [8:0] wr_data = 9'h000;
   logic       full, overflow, busy, dmx_txd;
   logic [9:0] level;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit [8:0] mq[$];
   frame_t   exp_q[$];
   longint   cyc = 0;
   longint   next_free = 0;
   longint   last_pop = 0;
   bit       movf = 1'b0;
   bit       started = 1'b0;
   int       pops = 0;
   bit       m_full, m_pop;
   bit [8:0] m_e;
   frame_t   m_f;

   // monitor state
   logic   prev_txd = 1'b1;
   bit     in_fr = 1'b0;
   bit     end_chk = 1'b0;
   frame_t cur;
   int     k = 0, flen = 0, bad = 0, first_bad = 0;
   logic   first_got = 1'b0;
   logic   mbusy;

   always #25 clk = ~clk;

   dmx_tx_core #(
      .CLKS_PER_BIT (80),
      .BREAK_BITS   (25),
      .MAB_BITS     (3),
      .FIFO_AW      (9)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr),
      .wr_data  (wr_data),
      .full     (full),
      .level    (level),
      .overflow (overflow),
      .busy     (busy),
      .dmx_txd  (dmx_txd)
   );

   function automatic logic exp_bit(input frame_t f, input int kk);
      int j;
      j = kk;
      if (f.sop) begin
         if (j < 25 * CPB) return 1'b0;
         if (j < BRKMAB) return 1'b1;
         j = j - BRKMAB;
      end
      if (j < CPB) return 1'b0;
      if (j < 9 * CPB) return f.data[(j - CPB) / CPB];
      return 1'b1;
   endfunction

   // Reference model: one FIFO queue plus "line free at cycle" arithmetic.
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         exp_q.delete();
         movf      = 1'b0;
         next_free = cyc + 1;
         last_pop  = cyc;
         started   = 1'b1;
      end else begin
         m_full = (mq.size() == DEPTH);
         m_pop  = (mq.size() != 0) && (cyc >= next_free);
         if (m_pop) begin
            m_e       = mq.pop_front();
            m_f.sop   = m_e[8];
            m_f.data  = m_e[7:0];
            m_f.start = cyc + 1;
            exp_q.push_back(m_f);
            last_pop  = cyc;
            next_free = cyc + 1 + (m_e[8] ? (BRKMAB + FRAME) : FRAME);
            pops++;
         end
         if (wr) begin
            if (m_full) movf = 1'b1;
            else mq.push_back(wr_data);
         end
      end
      cyc++;
   end

   // Monitor: per-cycle status against the model, and frame-by-frame line decode.
   always @(negedge clk) begin
      if (started) begin
         mbusy = (cyc > last_pop) && (cyc < next_free);
         checks++;
         if (level !== 10'(mq.size()) || full !== (mq.size() == DEPTH) ||
             overflow !== movf || busy !== mbusy) begin
            errors++;
            $display("FAIL status cyc=%0d got level=%0d full=%b overflow=%b busy=%b, required level=%0d full=%b overflow=%b busy=%b",
                     cyc, level, full, overflow, busy, mq.size(), (mq.size() == DEPTH), movf, mbusy);
         end
      end
      if (!started || rst) begin
         in_fr   = 1'b0;
         end_chk = 1'b0;
      end else begin
         if (end_chk) begin
            end_chk = 1'b0;
            checks++;
            if (dmx_txd !== 1'b1 || busy !== 1'b0) begin
               errors++;
               $display("FAIL frame_tail cyc=%0d got txd=%b busy=%b, required txd=1 busy=0", cyc, dmx_txd, busy);
            end
         end
         if (!in_fr && prev_txd === 1'b1 && dmx_txd === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL spurious_frame cyc=%0d got line low, required idle mark", cyc);
            end else begin
               cur = exp_q.pop_front();
               if (cyc != cur.start) begin
                  errors++;
                  $display("FAIL frame_start data=%02h got cycle %0d, required cycle %0d", cur.data, cyc, cur.start);
               end
               in_fr = 1'b1;
               k     = 0;
               bad   = 0;
               flen  = cur.sop ? (BRKMAB + FRAME) : FRAME;
            end
         end else if (!in_fr && exp_q.size() != 0 && cyc > exp_q[0].start) begin
            cur = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL frame_missing data=%02h got no start by cycle %0d, required start at %0d", cur.data, cyc, cur.start);
         end
         if (in_fr) begin
            if (dmx_txd !== exp_bit(cur, k)) begin
               if (bad == 0) begin
                  first_bad = k;
                  first_got = dmx_txd;
               end
               bad++;
            end
            k++;
            if (k == flen) begin
               checks++;
               if (bad != 0) begin
                  errors++;
                  $display("FAIL frame_wave sop=%0d data=%02h got %0d wrong cycles (first at offset %0d txd=%b), required %b there",
                           cur.sop, cur.data, bad, first_bad, first_got, exp_bit(cur, first_bad));
               end
               in_fr   = 1'b0;
               end_chk = 1'b1;
            end
         end
      end
      prev_txd = dmx_txd;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d got %0d, required %0d", name, cyc, got, req);
      end
   endtask

   task automatic push(input logic [8:0] d);
      wr      = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr      = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while ((mq.size() != 0 || cyc < next_free || exp_q.size() != 0 || in_fr) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_done"}, (n < budget), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [8:0] d;
      int         n;
      int         p0;

      repeat (3) @(negedge clk);
      rst = 1'b0;

      // idle after reset
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         check("idle_txd", dmx_txd, 1);
      end

      // start code then one slot
      push(9'h100);
      push(9'h0A5);
      wait_idle(8000, "two_slots");

      // slot without break: exact latency
      push(9'h055);
      check("latency_mark", dmx_txd, 1);
      @(negedge clk);
      check("latency_start", dmx_txd, 0);
      check("latency_busy", busy, 1);
      wait_idle(2000, "no_break");

      // randomised entries and gaps
      for (int i = 0; i < 10; i++) begin
         d[7:0] = 8'($urandom);
         d[8]   = ($urandom_range(0, 5) == 0);
         push(d);
         repeat ($urandom_range(0, 1200)) @(negedge clk);
      end
      wait_idle(40000, "random");

      // fill to full and overflow
      for (int i = 0; i < 514; i++) begin
         push({1'b0, 8'(i * 7 + 3)});
      end
      check("fill_level", level, 512);
      check("fill_full", full, 1);
      check("fill_overflow", overflow, 1);
      p0 = pops;
      n  = 0;
      while (pops < p0 + 30 && n < 30000) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", (n < 30000), 1);
      check("drain_overflow_sticky", overflow, 1);

      // reset in the middle of the data bits
      n = 0;
      while (cyc != last_pop + 1 + CPB + 300 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("mid_data_reached", (n < 2000), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_txd", dmx_txd, 1);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 0);
      push(9'h03C);
      wait_idle(3000, "after_reset");

      // push at full concurrent with a pop
      for (int i = 0; i < 513; i++) begin
         push({1'b0, 8'($urandom)});
      end
      check("refill_level", level, 512);
      check("refill_full", full, 1);
      check("refill_overflow", overflow, 0);
      n = 0;
      while (cyc != next_free && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("pop_cycle_reached", (n < 2000), 1);
      push(9'h0FF);
      check("popfull_level", level, 511);
      check("popfull_full", full, 0);
      check("popfull_overflow", overflow, 1);

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("final_txd", dmx_txd, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
